// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing with an optional sprite animation divider.
// Optional feature macro: VGA_TIMING_ANIM_EN compiles in the frame divider, anim_tick
// and anim_frame. Without it, anim_tick and anim_frame are tied to 0.
// The geometry parameters default to the standard 800x525 raster. They exist only so that a
// shorter raster can be instantiated. hs, vs, blank and frame_start are computed from the
// counters' next value and registered, which keeps them aligned with DrawX/DrawY.
module vga_timing_gen #(
    parameter int ANIM_DIV    = 6,
    parameter int ANIM_FRAMES = 4,
    parameter int H_ACTIVE    = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       sync,
    output logic       frame_start,
    output logic       anim_tick,
    output logic [3:0] anim_frame
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       fs_next;

    // Next raster position: x wraps every line, y advances only on the x wrap.
    always_comb begin
        x_next = DrawX + 10'd1;
        y_next = DrawY;
        if (DrawX == H_MAX) begin
            x_next = 10'd0;
            y_next = (DrawY == V_MAX) ? 10'd0 : DrawY + 10'd1;
        end
    end

    assign fs_next = (x_next == 10'd0) && (y_next == 10'd0);
    assign sync    = 1'b0;

    // Raster counters. Reset parks them on the last pixel so the first edge lands on (0,0).
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            DrawX <= H_MAX;
            DrawY <= V_MAX;
        end else begin
            DrawX <= x_next;
            DrawY <= y_next;
        end
    end

    // Sync, blank and frame_start are decoded from the next position, so they match DrawX/DrawY.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hs          <= !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
            vs          <= !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
            blank       <= (x_next <= H_ACT_LAST) && (y_next <= V_ACT_LAST);
            frame_start <= fs_next;
        end
    end

`ifdef VGA_TIMING_ANIM_EN
    localparam logic [7:0] DIV_MAX   = 8'(ANIM_DIV - 1);
    localparam logic [3:0] FRAME_MAX = 4'(ANIM_FRAMES - 1);

    logic [7:0] div_cnt;

    // Frame divider: counts frame starts and steps the animation frame every ANIM_DIV of them.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= 8'd0;
            anim_tick  <= 1'b0;
            anim_frame <= 4'd0;
        end else begin
            anim_tick <= 1'b0;
            if (fs_next) begin
                if (div_cnt == DIV_MAX) begin
                    div_cnt    <= 8'd0;
                    anim_tick  <= 1'b1;
                    anim_frame <= (anim_frame == FRAME_MAX) ? 4'd0 : anim_frame + 4'd1;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end
        end
    end
`else
    assign anim_tick  = 1'b0;
    assign anim_frame = 4'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks three vga_timing_gen instances against an arithmetic raster model.
// Instance a uses the full 800x525 raster. Instances b and c use a short 26x19 raster so that
// many frames fit in a short run. Instance c also uses ANIM_DIV=1 and ANIM_FRAMES=1.
// Expected animation behaviour follows VGA_TIMING_ANIM_EN.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_ANIM_EN
    localparam int ANIM_EN = 1;
`else
    localparam int ANIM_EN = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [9:0] dx_a, dy_a, dx_b, dy_b, dx_c, dy_c;
    logic       hs_a, vs_a, bl_a, sy_a, fs_a, tk_a;
    logic       hs_b, vs_b, bl_b, sy_b, fs_b, tk_b;
    logic       hs_c, vs_c, bl_c, sy_c, fs_c, tk_c;
    logic [3:0] af_a, af_b, af_c;

    int k = 0;          // rising edges since the last reset release
    int total = 0;
    int passed = 0;
    bit count_en = 1'b0;
    int hs_low_a = 0, vs_low_b = 0, blank_b = 0, fs_cnt_b = 0, tick_b = 0, tick_c = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .vga_clk(clk), .reset(reset), .DrawX(dx_a), .DrawY(dy_a), .hs(hs_a), .vs(vs_a),
        .blank(bl_a), .sync(sy_a), .frame_start(fs_a), .anim_tick(tk_a), .anim_frame(af_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FRONT(3), .H_SYNC(4), .H_BACK(3),
        .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut_b (
        .vga_clk(clk), .reset(reset), .DrawX(dx_b), .DrawY(dy_b), .hs(hs_b), .vs(vs_b),
        .blank(bl_b), .sync(sy_b), .frame_start(fs_b), .anim_tick(tk_b), .anim_frame(af_b)
    );

    vga_timing_gen #(
        .ANIM_DIV(1), .ANIM_FRAMES(1),
        .H_ACTIVE(16), .H_FRONT(3), .H_SYNC(4), .H_BACK(3),
        .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut_c (
        .vga_clk(clk), .reset(reset), .DrawX(dx_c), .DrawY(dy_c), .hs(hs_c), .vs(vs_c),
        .blank(bl_c), .sync(sy_c), .frame_start(fs_c), .anim_tick(tk_c), .anim_frame(af_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        total++;
        assert (obs === 32'(exp)) passed++;
        else $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
    endtask

    // Reference model: the position is (edges-1) mod frame size, split into line and pixel.
    task automatic chk_dut(input string n, input int ha, input int hf, input int hsy, input int hb,
                           input int va, input int vf, input int vsy, input int vb,
                           input int div, input int frames,
                           input logic [9:0] dx, input logic [9:0] dy, input logic h,
                           input logic v, input logic bl, input logic sy, input logic fs,
                           input logic tk, input logic [3:0] af);
        int ht, vt, p, x, y, nfs, e_hs, e_vs, e_bl, e_fs, e_tk, e_af;
        ht = ha + hf + hsy + hb;
        vt = va + vf + vsy + vb;
        if (k == 0) begin
            x = ht - 1; y = vt - 1;
            e_hs = 1; e_vs = 1; e_bl = 0; e_fs = 0; e_tk = 0; e_af = 0;
        end else begin
            p   = (k - 1) % (ht * vt);
            nfs = (k - 1) / (ht * vt) + 1;
            x = p % ht; y = p / ht;
            e_hs = (x >= ha + hf && x < ha + hf + hsy) ? 0 : 1;
            e_vs = (y >= va + vf && y < va + vf + vsy) ? 0 : 1;
            e_bl = (x < ha && y < va) ? 1 : 0;
            e_fs = (p == 0) ? 1 : 0;
            e_tk = (ANIM_EN == 1 && p == 0 && nfs % div == 0) ? 1 : 0;
            e_af = (ANIM_EN == 1) ? (nfs / div) % frames : 0;
        end
        chk({n, ".DrawX"}, 32'(dx), x);
        chk({n, ".DrawY"}, 32'(dy), y);
        chk({n, ".hs"}, 32'(h), e_hs);
        chk({n, ".vs"}, 32'(v), e_vs);
        chk({n, ".blank"}, 32'(bl), e_bl);
        chk({n, ".sync"}, 32'(sy), 0);
        chk({n, ".frame_start"}, 32'(fs), e_fs);
        chk({n, ".anim_tick"}, 32'(tk), e_tk);
        chk({n, ".anim_frame"}, 32'(af), e_af);
    endtask

    task automatic check_all();
        chk_dut("a", 640, 16, 96, 48, 480, 10, 2, 33, 6, 4,
                dx_a, dy_a, hs_a, vs_a, bl_a, sy_a, fs_a, tk_a, af_a);
        chk_dut("b", 16, 3, 4, 3, 12, 2, 2, 3, 6, 4,
                dx_b, dy_b, hs_b, vs_b, bl_b, sy_b, fs_b, tk_b, af_b);
        chk_dut("c", 16, 3, 4, 3, 12, 2, 2, 3, 1, 1,
                dx_c, dy_c, hs_c, vs_c, bl_c, sy_c, fs_c, tk_c, af_c);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            k++;
            #1;
            check_all();
            if (count_en) begin
                if (!hs_a) hs_low_a++;
                if (!vs_b) vs_low_b++;
                if (bl_b) blank_b++;
                if (fs_b) fs_cnt_b++;
                if (tk_b) tick_b++;
                if (tk_c) tick_c++;
            end
        end
    endtask

    // Reset asserts between edges; outputs must change before any clock edge arrives.
    task automatic do_reset(input int hold);
        @(negedge clk);
        reset = 1'b1;
        k = 0;
        #1;
        check_all();
        repeat (hold) begin
            @(posedge clk);
            #1;
            check_all();
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all();
    endtask

    initial begin
        // Reset state while held from time 0.
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Thirty short frames, plus the first 18 full lines of the full-size raster.
        count_en = 1'b1;
        run(30 * 494);
        count_en = 1'b0;
        chk("a.hs_low_cycles", 32'(hs_low_a), 18 * 96);
        chk("b.vs_low_cycles", 32'(vs_low_b), 30 * 2 * 26);
        chk("b.blank_cycles", 32'(blank_b), 30 * 16 * 12);
        chk("b.frame_starts", 32'(fs_cnt_b), 30);
        chk("b.anim_ticks", 32'(tick_b), ANIM_EN * 5);
        chk("c.anim_ticks", 32'(tick_c), ANIM_EN * 30);

        // Move into frame 31 at (20,14), where both syncs are low, then reset mid-pulse.
        run(385);
        chk("b.hs_before_abort", 32'(hs_b), 0);
        chk("b.vs_before_abort", 32'(vs_b), 0);
        chk("b.anim_frame_before_abort", 32'(af_b), ANIM_EN);
        do_reset(1);
        run(1);
        chk("b.first_edge_fs", 32'(fs_b), 1);
        chk("b.first_edge_blank", 32'(bl_b), 1);

        // Random mid-frame resets with random hold and run lengths.
        for (int i = 0; i < 4; i++) begin
            run($urandom_range(3000, 50));
            do_reset($urandom_range(3, 0));
        end
        run(7 * 494 + 13);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter ANIM_DIV, default 6: frame_start pulses per animation step; legal range 1..255.
REQ-002 Parameter ANIM_FRAMES, default 4: number of sprite animation frames; legal range 1..16.
REQ-003 vga_clk  in  1  pixel clock, 25 MHz nominal; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; the block's only clock and only reset are vga_clk and reset.
REQ-005 DrawX  out  10  current horizontal pixel count, 0..799.
REQ-006 DrawY  out  10  current vertical line count, 0..524.
REQ-007 hs  out  1  horizontal sync, active-low.
REQ-008 vs  out  1  vertical sync, active-low.
REQ-009 blank  out  1  1 = active video (DrawX<640 and DrawY<480), 0 = blanking; consumed directly by the sprite draw stage.
REQ-010 sync  out  1  composite sync, constant 0.
REQ-011 frame_start  out  1  one-cycle pulse while DrawX=0 and DrawY=0.
REQ-012 anim_tick  out  1  one-cycle pulse marking an animation step.
REQ-013 anim_frame  out  4  current sprite animation frame index, 0..ANIM_FRAMES-1.

Function
REQ-014 Horizontal counter SHALL increment every cycle and wrap 799->0.
REQ-015 Vertical counter SHALL increment only when the horizontal counter wraps; it wraps 524->0 on the same edge.
REQ-016 DrawX/DrawY SHALL be the counter registers themselves; hs, vs, blank and frame_start are registered and SHALL describe the same (DrawX, DrawY) visible in that cycle, with zero relative latency.
REQ-017 hs SHALL be 0 exactly when DrawX is 656..751, otherwise 1.
REQ-018 vs SHALL be 0 exactly when DrawY is 490..491, otherwise 1.
REQ-019 blank SHALL be 1 exactly when DrawX<=639 and DrawY<=479.
REQ-020 Frame period SHALL be 800*525 = 420000 cycles; line period 800 cycles.
REQ-021 Frame-divider counter (8 bits) SHALL increment on each cycle frame_start=1; on the frame_start where it equals ANIM_DIV-1 it clears to 0, anim_tick=1 in that same cycle, and anim_frame advances on that same edge.
REQ-022 anim_frame SHALL increment by 1 per anim_tick and wrap ANIM_FRAMES-1 -> 0; with ANIM_FRAMES=1 it remains 0.
REQ-023 With ANIM_DIV=1, anim_tick SHALL coincide with every frame_start.
REQ-024 anim_tick SHALL never assert outside a frame_start cycle.

Reset
REQ-025 While reset=1, outputs SHALL be asynchronously forced to: DrawX=799, DrawY=524, hs=1, vs=1, blank=0, sync=0, frame_start=0, anim_tick=0, anim_frame=0; frame-divider counter=0.
REQ-026 The first rising edge after reset deasserts SHALL produce DrawX=0, DrawY=0, blank=1, frame_start=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately; no partial sync pulse continues and the animation state restarts from 0.

Configuration
REQ-028 Macro VGA_TIMING_ANIM_EN defined: the frame divider, anim_tick and anim_frame logic are compiled in as REQ-021..REQ-024.
REQ-029 Macro VGA_TIMING_ANIM_EN undefined: no divider registers exist, anim_tick is constant 0, anim_frame is constant 0, and all other behaviour is unchanged.

Verification
REQ-030 Release reset; count edges -> frame_start at edge 1 (0,0), next at edge 420001; hs low for exactly 96 cycles per line starting at DrawX=656.
REQ-031 Run one frame -> vs low for exactly 1600 cycles, starting at DrawX=0, DrawY=490; blank=1 for exactly 307200 cycles.
REQ-032 Defaults, ANIM_EN defined -> anim_tick on the 6th, 12th, 18th, 24th frame_start; anim_frame 0->1->2->3->0.
REQ-033 ANIM_DIV=1, ANIM_FRAMES=1 -> anim_tick on every frame_start; anim_frame stays 0.
REQ-034 Assert reset at DrawX=700, DrawY=490 (hs=0, vs=0) -> same cycle hs=1, vs=1, DrawX=799, DrawY=524, anim_frame=0; after release, REQ-026 holds.
REQ-035 Build without VGA_TIMING_ANIM_EN, run 10 frames -> anim_tick and anim_frame remain 0; sync and blank timing match REQ-030/REQ-031.
